mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter READ_LAT, default 1: cycles a lane holds an SRAM port in ACCESS before sampling dout_x; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid_x  input  1  lane x (x = 0..2) request valid.
REQ-005 req_ready_x  output  1  lane x accepts a request this cycle.
REQ-006 req_we_x  input  1  1 = write, 0 = read.
REQ-007 req_addr_x  input  32  byte address, word aligned.
REQ-008 req_wdata_x  input  32  write data.
REQ-009 rsp_valid_x  output  1  lane x response valid.
REQ-010 rsp_ready_x  input  1  consumer takes response.
REQ-011 rsp_rdata_x  output  32  read data; 0 for writes and errors.
REQ-012 rsp_err_x  output  1  request rejected (address 0 or misaligned).
REQ-013 cs  output  1  SRAM chip select.
REQ-014 oe_x, we_x  output  1 each  SRAM port x output/write enable.
REQ-015 addr_x, din_x  output  32 each  SRAM port x address and write data.
REQ-016 dout_x  input  32  SRAM port x read data.

Function
REQ-017 Each lane x SHALL run an independent FSM: IDLE, PEND, ACCESS, RECOVER, RESP; lane x drives only SRAM port x.
REQ-018 req_ready_x SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid_x and req_ready_x are both 1, and we/addr/wdata are captured then.
REQ-019 On accept, a request with addr == 0 or addr[1:0] != 0 SHALL go directly to RESP with rsp_err_x = 1, rsp_rdata_x = 0, and never touch the SRAM port.
REQ-020 On accept, a valid request SHALL go to ACCESS unless a write conflict exists (REQ-025), in which case it goes to PEND.
REQ-021 In ACCESS, addr_x/din_x SHALL drive the captured address/data, we_x = captured we, oe_x = not captured we, for exactly READ_LAT cycles.
REQ-022 For reads, dout_x SHALL be sampled at the edge ending the last ACCESS cycle into the lane response register.
REQ-023 RECOVER SHALL last exactly one cycle with oe_x = we_x = 0 and addr_x held, so every access produces a fresh enable edge at the SRAM.
REQ-024 Latency: accept at the edge ending cycle T; ACCESS in cycles T+1..T+READ_LAT; RECOVER in T+READ_LAT+1; rsp_valid_x = 1 from T+READ_LAT+2.
REQ-025 Write conflict: lane x is blocked while any lane y < x is in ACCESS or RECOVER, or is entering ACCESS on the same edge, with a write to the same address as lane x's write. Lane x SHALL remain in PEND while blocked and enter ACCESS on the first unblocked edge.
REQ-026 In RESP, rsp_valid_x SHALL be 1 with stable rsp_rdata_x/rsp_err_x until the edge where rsp_ready_x = 1, then return to IDLE. A new request is not accepted in that same cycle.
REQ-027 Write responses SHALL have rsp_rdata_x = 0 and rsp_err_x = 0.
REQ-028 cs SHALL be 1 in any cycle in which at least one lane is in ACCESS, else 0.
REQ-029 oe_x, we_x SHALL be 0 in IDLE, PEND, RECOVER, RESP; addr_x/din_x SHALL hold their last driven value outside ACCESS/RECOVER.
REQ-030 Simultaneous accepts on all three lanes SHALL proceed in parallel with no mutual stalling except per REQ-025.
REQ-031 The ACCESS cycle counter SHALL be 4 bits and reload on every entry to ACCESS.

Reset
REQ-032 With reset = 1 at an edge, all lanes SHALL go to IDLE. Outputs: req_ready_x = 1, rsp_valid_x = 0, rsp_rdata_x = 0, rsp_err_x = 0, cs = 0, oe_x = we_x = 0, addr_x = din_x = 0.
REQ-033 Reset during ACCESS, PEND or RESP SHALL abandon the operation with no response; the SRAM write may already have occurred.

Verification
REQ-034 Scenario: READ_LAT = 1, lane 0 read 0x0000_0010, SRAM dout_0 = 0xDEAD_BEEF -> oe_0 high 1 cycle; rsp_valid_0 in T+3 with rdata 0xDEAD_BEEF, err 0.
REQ-035 Scenario: lane 1 write 0x20 = 0x1234_5678, then lane 2 read 0x20 after response -> we_1 pulse 1 cycle; read returns 0x1234_5678.
REQ-036 Scenario: lane 0 addr 0x0, lane 1 addr 0x22 -> both rsp_err = 1 in T+1, rdata 0, cs never asserted.
REQ-037 Scenario: lanes 0 and 2 accept writes to 0x40 on the same edge -> lane 2 in PEND; we_2 rises only after lane 0 leaves RECOVER.
REQ-038 Scenario: READ_LAT = 3, rsp_ready_0 held 0 for 5 cycles -> rsp_valid_0 stable with data held, req_ready_0 = 0 throughout.
REQ-039 Scenario: reset asserted in the second ACCESS cycle (READ_LAT = 3) -> next cycle all outputs at reset values, no rsp_valid ever for that request.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Three-lane request controller: each lane owns one SRAM port; request to response takes READ_LAT+2 cycles (errors: 1).
// req_ready only in IDLE; a response is held stable until rsp_ready; a later-lane write to an in-flight write address waits in PEND.
module mem_req_ctrl #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_we_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic [31:0] rsp_rdata_0,
  output logic        rsp_err_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_we_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_rdata_1,
  output logic        rsp_err_1,
  input  logic        req_valid_2,
  output logic        req_ready_2,
  input  logic        req_we_2,
  input  logic [31:0] req_addr_2,
  input  logic [31:0] req_wdata_2,
  output logic        rsp_valid_2,
  input  logic        rsp_ready_2,
  output logic [31:0] rsp_rdata_2,
  output logic        rsp_err_2,
  output logic        cs,
  output logic        oe_0,
  output logic        we_0,
  output logic [31:0] addr_0,
  output logic [31:0] din_0,
  input  logic [31:0] dout_0,
  output logic        oe_1,
  output logic        we_1,
  output logic [31:0] addr_1,
  output logic [31:0] din_1,
  input  logic [31:0] dout_1,
  output logic        oe_2,
  output logic        we_2,
  output logic [31:0] addr_2,
  output logic [31:0] din_2,
  input  logic [31:0] dout_2
);

  localparam int NL = 3;
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_ACCESS,
    S_RECOVER,
    S_RESP
  } state_e;

  state_e        state_q     [NL];
  state_e        state_d     [NL];
  logic [NL-1:0] we_q, we_d;
  logic [NL-1:0] err_q, err_d;
  logic [31:0]   addr_q      [NL];
  logic [31:0]   addr_d      [NL];
  logic [31:0]   wdata_q     [NL];
  logic [31:0]   wdata_d     [NL];
  logic [31:0]   rdata_q     [NL];
  logic [31:0]   rdata_d     [NL];
  logic [31:0]   sram_addr_q [NL];
  logic [31:0]   sram_addr_d [NL];
  logic [31:0]   sram_din_q  [NL];
  logic [31:0]   sram_din_d  [NL];
  logic [3:0]    cnt_q       [NL];
  logic [3:0]    cnt_d       [NL];

  logic [NL-1:0] in_valid, in_we, in_rsp_ready;
  logic [31:0]   in_addr  [NL];
  logic [31:0]   in_wdata [NL];
  logic [31:0]   in_dout  [NL];
  logic [NL-1:0] enter_acc;
  logic [NL-1:0] in_access;

  assign in_valid     = {req_valid_2, req_valid_1, req_valid_0};
  assign in_we        = {req_we_2, req_we_1, req_we_0};
  assign in_rsp_ready = {rsp_ready_2, rsp_ready_1, rsp_ready_0};
  assign in_addr[0]   = req_addr_0;
  assign in_addr[1]   = req_addr_1;
  assign in_addr[2]   = req_addr_2;
  assign in_wdata[0]  = req_wdata_0;
  assign in_wdata[1]  = req_wdata_1;
  assign in_wdata[2]  = req_wdata_2;
  assign in_dout[0]   = dout_0;
  assign in_dout[1]   = dout_1;
  assign in_dout[2]   = dout_2;

  // Lanes are evaluated in index order so a higher lane sees what lower lanes are starting this edge.
  always_comb begin
    logic        blocked;
    logic        cand_we;
    logic [31:0] cand_addr;
    enter_acc = '0;
    we_d      = we_q;
    err_d     = err_q;
    for (int x = 0; x < NL; x++) begin
      state_d[x]     = state_q[x];
      addr_d[x]      = addr_q[x];
      wdata_d[x]     = wdata_q[x];
      rdata_d[x]     = rdata_q[x];
      sram_addr_d[x] = sram_addr_q[x];
      sram_din_d[x]  = sram_din_q[x];
      cnt_d[x]       = cnt_q[x];

      cand_we   = (state_q[x] == S_IDLE) ? in_we[x]   : we_q[x];
      cand_addr = (state_q[x] == S_IDLE) ? in_addr[x] : addr_q[x];
      blocked   = 1'b0;
      for (int y = 0; y < x; y++) begin
        if (cand_we &&
            ((((state_q[y] == S_ACCESS) || (state_q[y] == S_RECOVER)) &&
              we_q[y] && (addr_q[y] == cand_addr)) ||
             (enter_acc[y] && we_d[y] && (addr_d[y] == cand_addr)))) begin
          blocked = 1'b1;
        end
      end

      case (state_q[x])
        S_IDLE: begin
          if (in_valid[x]) begin
            we_d[x]    = in_we[x];
            addr_d[x]  = in_addr[x];
            wdata_d[x] = in_wdata[x];
            rdata_d[x] = '0;
            if ((in_addr[x] == 32'd0) || (in_addr[x][1:0] != 2'b00)) begin
              err_d[x]   = 1'b1;
              state_d[x] = S_RESP;
            end else begin
              err_d[x] = 1'b0;
              if (blocked) begin
                state_d[x] = S_PEND;
              end else begin
                state_d[x]   = S_ACCESS;
                enter_acc[x] = 1'b1;
              end
            end
          end
        end
        S_PEND: begin
          if (!blocked) begin
            state_d[x]   = S_ACCESS;
            enter_acc[x] = 1'b1;
          end
        end
        S_ACCESS: begin
          if (cnt_q[x] == 4'd0) begin
            state_d[x] = S_RECOVER;
            rdata_d[x] = we_q[x] ? 32'd0 : in_dout[x];
          end else begin
            cnt_d[x] = cnt_q[x] - 4'd1;
          end
        end
        S_RECOVER: state_d[x] = S_RESP;
        S_RESP: begin
          if (in_rsp_ready[x]) begin
            state_d[x] = S_IDLE;
            rdata_d[x] = '0;
            err_d[x]   = 1'b0;
          end
        end
        default: state_d[x] = S_IDLE;
      endcase

      if (enter_acc[x]) begin
        cnt_d[x]       = LAT_M1;
        sram_addr_d[x] = addr_d[x];
        sram_din_d[x]  = wdata_d[x];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q  <= '0;
      err_q <= '0;
      for (int i = 0; i < NL; i++) begin
        state_q[i]     <= S_IDLE;
        addr_q[i]      <= '0;
        wdata_q[i]     <= '0;
        rdata_q[i]     <= '0;
        sram_addr_q[i] <= '0;
        sram_din_q[i]  <= '0;
        cnt_q[i]       <= '0;
      end
    end else begin
      we_q  <= we_d;
      err_q <= err_d;
      for (int i = 0; i < NL; i++) begin
        state_q[i]     <= state_d[i];
        addr_q[i]      <= addr_d[i];
        wdata_q[i]     <= wdata_d[i];
        rdata_q[i]     <= rdata_d[i];
        sram_addr_q[i] <= sram_addr_d[i];
        sram_din_q[i]  <= sram_din_d[i];
        cnt_q[i]       <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_acc
    assign in_access[g] = (state_q[g] == S_ACCESS);
  end

  assign cs = |in_access;

  assign req_ready_0 = (state_q[0] == S_IDLE);
  assign req_ready_1 = (state_q[1] == S_IDLE);
  assign req_ready_2 = (state_q[2] == S_IDLE);
  assign rsp_valid_0 = (state_q[0] == S_RESP);
  assign rsp_valid_1 = (state_q[1] == S_RESP);
  assign rsp_valid_2 = (state_q[2] == S_RESP);
  assign rsp_rdata_0 = rdata_q[0];
  assign rsp_rdata_1 = rdata_q[1];
  assign rsp_rdata_2 = rdata_q[2];
  assign rsp_err_0   = err_q[0];
  assign rsp_err_1   = err_q[1];
  assign rsp_err_2   = err_q[2];

  assign oe_0   = in_access[0] & ~we_q[0];
  assign we_0   = in_access[0] &  we_q[0];
  assign oe_1   = in_access[1] & ~we_q[1];
  assign we_1   = in_access[1] &  we_q[1];
  assign oe_2   = in_access[2] & ~we_q[2];
  assign we_2   = in_access[2] &  we_q[2];
  assign addr_0 = sram_addr_q[0];
  assign addr_1 = sram_addr_q[1];
  assign addr_2 = sram_addr_q[2];
  assign din_0  = sram_din_q[0];
  assign din_1  = sram_din_q[1];
  assign din_2  = sram_din_q[2];

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: instance a uses READ_LAT=1, instance b READ_LAT=3, each with its own word SRAM model.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  a_rv, a_rr, a_rwe, a_rspv, a_rspr, a_err, a_oe, a_wen;
  logic [31:0] a_raddr [3];
  logic [31:0] a_wdat  [3];
  logic [31:0] a_rdata [3];
  logic [31:0] a_addr  [3];
  logic [31:0] a_din   [3];
  logic [31:0] a_dout  [3];
  logic        a_cs;

  logic [2:0]  b_rv, b_rr, b_rwe, b_rspv, b_rspr, b_err, b_oe, b_wen;
  logic [31:0] b_raddr [3];
  logic [31:0] b_wdat  [3];
  logic [31:0] b_rdata [3];
  logic [31:0] b_addr  [3];
  logic [31:0] b_din   [3];
  logic [31:0] b_dout  [3];
  logic        b_cs;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_da, ld_db;

  int n_chk = 0;
  int n_err = 0;

  mem_req_ctrl #(.READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid_0(a_rv[0]), .req_ready_0(a_rr[0]), .req_we_0(a_rwe[0]), .req_addr_0(a_raddr[0]), .req_wdata_0(a_wdat[0]),
    .rsp_valid_0(a_rspv[0]), .rsp_ready_0(a_rspr[0]), .rsp_rdata_0(a_rdata[0]), .rsp_err_0(a_err[0]),
    .req_valid_1(a_rv[1]), .req_ready_1(a_rr[1]), .req_we_1(a_rwe[1]), .req_addr_1(a_raddr[1]), .req_wdata_1(a_wdat[1]),
    .rsp_valid_1(a_rspv[1]), .rsp_ready_1(a_rspr[1]), .rsp_rdata_1(a_rdata[1]), .rsp_err_1(a_err[1]),
    .req_valid_2(a_rv[2]), .req_ready_2(a_rr[2]), .req_we_2(a_rwe[2]), .req_addr_2(a_raddr[2]), .req_wdata_2(a_wdat[2]),
    .rsp_valid_2(a_rspv[2]), .rsp_ready_2(a_rspr[2]), .rsp_rdata_2(a_rdata[2]), .rsp_err_2(a_err[2]),
    .cs(a_cs),
    .oe_0(a_oe[0]), .we_0(a_wen[0]), .addr_0(a_addr[0]), .din_0(a_din[0]), .dout_0(a_dout[0]),
    .oe_1(a_oe[1]), .we_1(a_wen[1]), .addr_1(a_addr[1]), .din_1(a_din[1]), .dout_1(a_dout[1]),
    .oe_2(a_oe[2]), .we_2(a_wen[2]), .addr_2(a_addr[2]), .din_2(a_din[2]), .dout_2(a_dout[2])
  );

  mem_req_ctrl #(.READ_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid_0(b_rv[0]), .req_ready_0(b_rr[0]), .req_we_0(b_rwe[0]), .req_addr_0(b_raddr[0]), .req_wdata_0(b_wdat[0]),
    .rsp_valid_0(b_rspv[0]), .rsp_ready_0(b_rspr[0]), .rsp_rdata_0(b_rdata[0]), .rsp_err_0(b_err[0]),
    .req_valid_1(b_rv[1]), .req_ready_1(b_rr[1]), .req_we_1(b_rwe[1]), .req_addr_1(b_raddr[1]), .req_wdata_1(b_wdat[1]),
    .rsp_valid_1(b_rspv[1]), .rsp_ready_1(b_rspr[1]), .rsp_rdata_1(b_rdata[1]), .rsp_err_1(b_err[1]),
    .req_valid_2(b_rv[2]), .req_ready_2(b_rr[2]), .req_we_2(b_rwe[2]), .req_addr_2(b_raddr[2]), .req_wdata_2(b_wdat[2]),
    .rsp_valid_2(b_rspv[2]), .rsp_ready_2(b_rspr[2]), .rsp_rdata_2(b_rdata[2]), .rsp_err_2(b_err[2]),
    .cs(b_cs),
    .oe_0(b_oe[0]), .we_0(b_wen[0]), .addr_0(b_addr[0]), .din_0(b_din[0]), .dout_0(b_dout[0]),
    .oe_1(b_oe[1]), .we_1(b_wen[1]), .addr_1(b_addr[1]), .din_1(b_din[1]), .dout_1(b_dout[1]),
    .oe_2(b_oe[2]), .we_2(b_wen[2]), .addr_2(b_addr[2]), .din_2(b_din[2]), .dout_2(b_dout[2])
  );

  // Word-addressed SRAM models: combinational read, write on the rising edge while we_x is high.
  for (genvar g = 0; g < 3; g++) begin : g_rd
    assign a_dout[g] = mem_a[a_addr[g][9:2]];
    assign b_dout[g] = mem_b[b_addr[g][9:2]];
  end

  always @(posedge clk) begin
    if (ld_en) begin
      mem_a[ld_idx] <= ld_da;
      mem_b[ld_idx] <= ld_db;
    end
    for (int i = 0; i < 3; i++) begin
      if (a_wen[i]) mem_a[a_addr[i][9:2]] <= a_din[i];
      if (b_wen[i]) mem_b[b_addr[i][9:2]] <= b_din[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int rsp_seen;

  initial begin
    reset  = 1'b1;
    ld_en  = 1'b0; ld_idx = '0; ld_da = '0; ld_db = '0;
    a_rv = '0; a_rwe = '0; a_rspr = '0;
    b_rv = '0; b_rwe = '0; b_rspr = '0;
    for (int i = 0; i < 3; i++) begin
      a_raddr[i] = '0; a_wdat[i] = '0;
      b_raddr[i] = '0; b_wdat[i] = '0;
    end
    tick();
    ld_en = 1'b1; ld_idx = 8'd4; ld_da = 32'hDEAD_BEEF; ld_db = 32'hCAFE_F00D;
    tick();
    ld_en = 1'b0;
    reset = 1'b0;

    // reset state
    check("rst_req_ready", {29'd0, a_rr}, 32'h7);
    check("rst_rsp_valid", {29'd0, a_rspv}, 32'h0);
    check("rst_cs", {31'd0, a_cs}, 32'h0);
    check("rst_enables", {26'd0, a_oe, a_wen}, 32'h0);
    check("rst_addr0", a_addr[0], 32'h0);

    // lane 0 read at READ_LAT=1
    a_rv[0] = 1'b1; a_rwe[0] = 1'b0; a_raddr[0] = 32'h10;
    tick();
    a_rv[0] = 1'b0;
    check("rd_oe0_t1", {31'd0, a_oe[0]}, 32'h1);
    check("rd_cs_t1", {31'd0, a_cs}, 32'h1);
    check("rd_addr0_t1", a_addr[0], 32'h10);
    check("rd_ready0_t1", {31'd0, a_rr[0]}, 32'h0);
    tick();
    check("rd_oe0_t2", {31'd0, a_oe[0]}, 32'h0);
    check("rd_cs_t2", {31'd0, a_cs}, 32'h0);
    check("rd_addr0_t2", a_addr[0], 32'h10);
    check("rd_valid0_t2", {31'd0, a_rspv[0]}, 32'h0);
    tick();
    check("rd_valid0_t3", {31'd0, a_rspv[0]}, 32'h1);
    check("rd_rdata0_t3", a_rdata[0], 32'hDEAD_BEEF);
    check("rd_err0_t3", {31'd0, a_err[0]}, 32'h0);
    a_rspr[0] = 1'b1;
    tick();
    a_rspr[0] = 1'b0;
    check("rd_valid0_done", {31'd0, a_rspv[0]}, 32'h0);
    check("rd_ready0_done", {31'd0, a_rr[0]}, 32'h1);

    // lane 1 write then lane 2 read of the same word
    a_rv[1] = 1'b1; a_rwe[1] = 1'b1; a_raddr[1] = 32'h20; a_wdat[1] = 32'h1234_5678;
    tick();
    a_rv[1] = 1'b0;
    check("wr_we1_t1", {31'd0, a_wen[1]}, 32'h1);
    check("wr_oe1_t1", {31'd0, a_oe[1]}, 32'h0);
    check("wr_din1_t1", a_din[1], 32'h1234_5678);
    tick();
    check("wr_we1_t2", {31'd0, a_wen[1]}, 32'h0);
    tick();
    check("wr_valid1_t3", {31'd0, a_rspv[1]}, 32'h1);
    check("wr_rdata1_t3", a_rdata[1], 32'h0);
    check("wr_err1_t3", {31'd0, a_err[1]}, 32'h0);
    a_rspr[1] = 1'b1;
    tick();
    a_rspr[1] = 1'b0;
    a_rv[2] = 1'b1; a_rwe[2] = 1'b0; a_raddr[2] = 32'h20;
    tick();
    a_rv[2] = 1'b0;
    tick();
    tick();
    check("rbk_valid2", {31'd0, a_rspv[2]}, 32'h1);
    check("rbk_rdata2", a_rdata[2], 32'h1234_5678);
    a_rspr[2] = 1'b1;
    tick();
    a_rspr[2] = 1'b0;

    // address 0 and misaligned address are rejected without touching the SRAM
    a_rv[0] = 1'b1; a_raddr[0] = 32'h0;
    a_rv[1] = 1'b1; a_rwe[1] = 1'b0; a_raddr[1] = 32'h22;
    check("err_cs_t0", {31'd0, a_cs}, 32'h0);
    tick();
    a_rv[0] = 1'b0; a_rv[1] = 1'b0;
    check("err_valid01_t1", {30'd0, a_rspv[1:0]}, 32'h3);
    check("err_err01_t1", {30'd0, a_err[1:0]}, 32'h3);
    check("err_rdata0", a_rdata[0], 32'h0);
    check("err_rdata1", a_rdata[1], 32'h0);
    check("err_cs_t1", {31'd0, a_cs}, 32'h0);
    check("err_oe01", {30'd0, a_oe[1:0]}, 32'h0);
    a_rspr = 3'b011;
    tick();
    a_rspr = '0;

    // same-address writes on lanes 0 and 2: lane 2 waits until lane 0 has left RECOVER
    a_rv[0] = 1'b1; a_rwe[0] = 1'b1; a_raddr[0] = 32'h40; a_wdat[0] = 32'hAAAA_0000;
    a_rv[2] = 1'b1; a_rwe[2] = 1'b1; a_raddr[2] = 32'h40; a_wdat[2] = 32'hBBBB_2222;
    tick();
    a_rv[0] = 1'b0; a_rv[2] = 1'b0;
    check("cf_we0_t1", {31'd0, a_wen[0]}, 32'h1);
    check("cf_we2_t1", {31'd0, a_wen[2]}, 32'h0);
    check("cf_ready2_t1", {31'd0, a_rr[2]}, 32'h0);
    tick();
    check("cf_we02_t2", {30'd0, a_wen[2], a_wen[0]}, 32'h0);
    tick();
    check("cf_valid0_t3", {31'd0, a_rspv[0]}, 32'h1);
    check("cf_we2_t3", {31'd0, a_wen[2]}, 32'h0);
    tick();
    check("cf_we2_t4", {31'd0, a_wen[2]}, 32'h1);
    check("cf_din2_t4", a_din[2], 32'hBBBB_2222);
    check("cf_addr2_t4", a_addr[2], 32'h40);
    tick();
    tick();
    check("cf_valid2_t6", {31'd0, a_rspv[2]}, 32'h1);
    check("cf_mem40", mem_a[16], 32'hBBBB_2222);
    a_rspr = 3'b101;
    tick();
    a_rspr = '0;

    // three lanes at once, no conflict (read of a word being written is not a write conflict)
    a_rv = 3'b111; a_rwe = 3'b011;
    a_raddr[0] = 32'h50; a_wdat[0] = 32'h1111_1111;
    a_raddr[1] = 32'h54; a_wdat[1] = 32'h2222_2222;
    a_raddr[2] = 32'h50;
    tick();
    a_rv = '0;
    check("par_we_t1", {29'd0, a_wen}, 32'h3);
    check("par_oe_t1", {29'd0, a_oe}, 32'h4);
    tick();
    tick();
    check("par_valid_t3", {29'd0, a_rspv}, 32'h7);
    a_rspr = 3'b111;
    tick();
    a_rspr = '0;
    check("par_ready_done", {29'd0, a_rr}, 32'h7);

    // READ_LAT=3 read with response backpressure
    b_rv[0] = 1'b1; b_rwe[0] = 1'b0; b_raddr[0] = 32'h10;
    tick();
    b_rv[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("l3_oe0_t%0d", c), {31'd0, b_oe[0]}, 32'h1);
      tick();
    end
    check("l3_oe0_t4", {31'd0, b_oe[0]}, 32'h0);
    check("l3_valid0_t4", {31'd0, b_rspv[0]}, 32'h0);
    tick();
    b_rv[0] = 1'b1; b_raddr[0] = 32'h30;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid0_%0d", c), {31'd0, b_rspv[0]}, 32'h1);
      check($sformatf("bp_rdata0_%0d", c), b_rdata[0], 32'hCAFE_F00D);
      check($sformatf("bp_ready0_%0d", c), {31'd0, b_rr[0]}, 32'h0);
      tick();
    end
    b_rv[0] = 1'b0;
    check("bp_valid0_hold", {31'd0, b_rspv[0]}, 32'h1);
    b_rspr[0] = 1'b1;
    tick();
    b_rspr[0] = 1'b0;
    check("bp_valid0_done", {31'd0, b_rspv[0]}, 32'h0);
    check("bp_ready0_done", {31'd0, b_rr[0]}, 32'h1);

    // reset in the second ACCESS cycle abandons the read
    b_rv[0] = 1'b1; b_raddr[0] = 32'h10;
    tick();
    b_rv[0] = 1'b0;
    check("ra_oe0_t1", {31'd0, b_oe[0]}, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ra_ready", {29'd0, b_rr}, 32'h7);
    check("ra_valid", {29'd0, b_rspv}, 32'h0);
    check("ra_cs", {31'd0, b_cs}, 32'h0);
    check("ra_enables", {26'd0, b_oe, b_wen}, 32'h0);
    check("ra_addr0", b_addr[0], 32'h0);
    check("ra_din0", b_din[0], 32'h0);
    check("ra_rdata0", b_rdata[0], 32'h0);
    check("ra_err0", {31'd0, b_err[0]}, 32'h0);
    rsp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (b_rspv[0]) rsp_seen++;
      tick();
    end
    check("ra_no_rsp", rsp_seen, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
